// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Each requester has a valid/ready handshake. Writes to register 0 are accepted
// and then discarded. The write port is driven from registers, and a saturating
// counter records the cycles in which the write port was contended.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_DEPTH  = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(REG_DEPTH),
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
  output logic                           rf_wr,
  output logic [ADDR_WIDTH-1:0]          rf_rw,
  output logic [DATA_WIDTH-1:0]          rf_d,
  output logic [CNT_WIDTH-1:0]           conflict_cnt
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic [PtrW:0] NumReqW = (PtrW + 1)'(NUM_REQ);

  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  rf_wr_q, rf_wr_d;
  logic [ADDR_WIDTH-1:0] rf_rw_q, rf_rw_d;
  logic [DATA_WIDTH-1:0] rf_d_q, rf_d_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  grant_vld;
  logic [PtrW-1:0]       grant_idx;
  logic [PtrW:0]         scan_idx;
  logic                  multi_valid;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[ADDR_WIDTH*gi +: ADDR_WIDTH];
    assign data_arr[gi] = req_data[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  // Two or more bits set: clearing the lowest set bit still leaves a bit set.
  assign multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));

  // Round-robin scan that starts at rr_ptr. The grant depends only on valid,
  // pointer, hold and rst.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + k[PtrW:0];
      if (scan_idx >= NumReqW) scan_idx = scan_idx - NumReqW;
      if (!grant_vld && req_valid[scan_idx[PtrW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[PtrW-1:0];
      end
    end
    if (rst || hold) grant_vld = 1'b0;
  end

  // One-hot ready to the winning requester.
  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // Next state for the write port, the pointer and the contention counter.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rf_wr_d  = 1'b0;
    rf_rw_d  = rf_rw_q;
    rf_d_d   = rf_d_q;
    cnt_d    = cnt_q;
    if (grant_vld) begin
      rf_rw_d  = addr_arr[grant_idx];
      rf_d_d   = data_arr[grant_idx];
      // Register 0 is hardwired, so the write is consumed but never enabled.
      rf_wr_d  = |addr_arr[grant_idx];
      rr_ptr_d = ({1'b0, grant_idx} == NumReqW - 1'b1) ? '0 : grant_idx + 1'b1;
    end
    if (!hold && multi_valid && cnt_q != {CNT_WIDTH{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers. The synchronous reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rf_wr_q  <= 1'b0;
      rf_rw_q  <= '0;
      rf_d_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rf_wr_q  <= rf_wr_d;
      rf_rw_q  <= rf_rw_d;
      rf_d_q   <= rf_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_wr        = rf_wr_q;
  assign rf_rw        = rf_rw_q;
  assign rf_d         = rf_d_q;
  assign conflict_cnt = cnt_q;

endmodule
